sprite_line_scanner: RTL and testbench
======================================

Name: sprite_line_scanner

Overview:
- Read-side companion to the sprite attribute register file.
- Once per scanline, scans the 8 sprite attribute bytes and 8 sprite Y positions in priority order and selects up to MAX_PER_LINE sprites that intersect the current line.
- Streams the selected sprites (index, attribute, row within sprite) to the downstream sprite pixel fetcher over a valid/ready handshake.

Parameters:
- MAX_PER_LINE, 4: maximum sprites emitted per line; legal range 1..8.
- SPRITE_H, 16: sprite height in lines; legal range 1..16.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- line_start  input  1  single-cycle pulse that starts a scan for line_y.
- line_y  input  10  current scanline number; sampled when line_start=1.
- attr_bus  input  64  attribute bytes, sprite n at [8n+7:8n]. Bit 7 = visible, bit 6 = hflip, bit 5 = vflip, bits 4:0 = passed through.
- y_bus  input  80  sprite top Y, sprite n at [10n+9:10n].
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the entry.
- out_index  output  3  sprite number of the current entry.
- out_attr  output  8  attribute byte captured during the scan.
- out_row  output  4  row within the sprite to fetch, vflip already applied.
- busy  output  1  high whenever state is not IDLE.
- hit_count  output  4  number of sprites stored for the line, 0..MAX_PER_LINE.
- overflow  output  1  more than MAX_PER_LINE sprites hit the line.

Behaviour:
- Reset:
  - state = IDLE.
  - out_valid, busy, overflow = 0; hit_count = 0.
  - out_index, out_attr, out_row = 0; internal buffer cleared.
  - Reset asserted mid-scan or mid-emit returns to IDLE on that edge; any pending entries are discarded.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - line_start=1: latch line_y, set scan index = 0, clear hit_count and overflow, go to SCAN.
- SCAN: evaluates one sprite per cycle, index 0 to 7. Lower index = higher priority. Takes exactly 8 cycles.
  - Inputs are read live in the cycle each sprite is evaluated; they are not snapshotted at line_start.
  - diff = latched_y - y_n, 10-bit modular subtraction.
  - hit = attr[7] && (diff < SPRITE_H). Wrap-around case: y_n = 1020, line 2 gives diff = 6, which is a hit.
  - row = attr[5] ? (SPRITE_H-1-diff[3:0]) : diff[3:0].
  - hit and hit_count < MAX_PER_LINE: store {n, attr, row}, increment hit_count.
  - hit and hit_count == MAX_PER_LINE: set overflow = 1, do not store.
  - After sprite 7: go to EMIT if hit_count > 0, otherwise IDLE.
- EMIT:
  - Entries are presented in stored order (ascending index).
  - out_valid = 1 with registered fields; fields stay stable until the transfer.
  - Transfer occurs when out_valid && out_ready; the next entry appears in the following cycle (zero bubble).
  - After the last transfer: out_valid = 0, go to IDLE.
- hit_count and overflow hold their values until the next accepted line_start or Reset.
- busy = (state != IDLE).
- line_start while busy (SCAN or EMIT): abort and restart.
  - Latch the new line_y, clear the buffer, hit_count and overflow, and restart SCAN at index 0.
  - out_valid = 0 from the next cycle.
  - A handshake completing in the same cycle as line_start counts as transferred; all remaining entries are dropped.
- Reset has priority over line_start.
- out_ready is ignored while out_valid = 0.
- Latency: line_start at cycle 0 gives the first out_valid at cycle 9; with out_ready held high the last entry leaves at cycle 8 + hit_count.

Test Plan:
- Single sprite: attr0 = 0x80, y0 = 100, others invisible; line_start with line_y = 105 → one entry: index 0, attr 0x80, row 5. hit_count = 1, overflow = 0; out_valid first rises 9 cycles after line_start.
- Vflip and boundaries: attr3 = 0xA0, y3 = 200. Line 215 → row 0. Line 216 → no entries, busy drops after 8 scan cycles. Line 199 → no hit.
- Overflow: all 8 sprites visible at y = 50, line 60 → entries index 0,1,2,3, all row 10; hit_count = 4, overflow = 1.
- Backpressure: 3 hits, out_ready toggled 0,0,1,0,1,1 → each entry held stable while out_ready = 0; exactly 3 transfers in index order; then IDLE.
- Abort and wrap: y5 = 1020 visible, line 2 → hit, row 6. Pulse line_start (line 500) during EMIT → out_valid low next cycle, new 8-cycle scan starts, old entries are never emitted.
- Reset mid-SCAN at cycle 4 → next cycle busy = 0, out_valid = 0, hit_count = 0, overflow = 0.

Source files
------------

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: once per scanline, walks the eight sprite slots in
// priority order, keeps up to MAX_PER_LINE sprites that cover the line, and
// hands them to the pixel fetcher over a valid/ready stream.
module sprite_line_scanner #(
   parameter int MAX_PER_LINE = 4,
   parameter int SPRITE_H     = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        line_start,
   input  logic [9:0]  line_y,
   input  logic [63:0] attr_bus,
   input  logic [79:0] y_bus,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_index,
   output logic [7:0]  out_attr,
   output logic [3:0]  out_row,
   output logic        busy,
   output logic [3:0]  hit_count,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t state_r, state_next_s;

   logic [9:0] line_y_r,    line_y_n;
   logic [2:0] scan_idx_r,  scan_idx_n;
   logic [3:0] emit_ptr_r,  emit_ptr_n;
   logic [3:0] hit_count_r, hit_count_n;
   logic       overflow_r,  overflow_n;
   logic       out_valid_r, out_valid_n;
   logic [2:0] out_index_r, out_index_n;
   logic [7:0] out_attr_r,  out_attr_n;
   logic [3:0] out_row_r,   out_row_n;

   logic [2:0] buf_index_r [MAX_PER_LINE];
   logic [7:0] buf_attr_r  [MAX_PER_LINE];
   logic [3:0] buf_row_r   [MAX_PER_LINE];
   logic [2:0] buf_index_n [MAX_PER_LINE];
   logic [7:0] buf_attr_n  [MAX_PER_LINE];
   logic [3:0] buf_row_n   [MAX_PER_LINE];

   // Live evaluation of the sprite addressed by the scan index.
   logic [5:0] attr_base_s;
   logic [6:0] y_base_s;
   logic [7:0] cur_attr_s;
   logic [9:0] cur_y_s;
   logic [9:0] diff_s;
   logic [3:0] row_s;
   logic       hit_s;
   logic       store_s;
   logic       scan_done_s;
   logic       any_hit_s;
   logic       xfer_s;
   logic       last_s;

   assign attr_base_s = {scan_idx_r, 3'b000};
   assign y_base_s    = {4'b0000, scan_idx_r} * 7'd10;
   assign cur_attr_s  = attr_bus[attr_base_s +: 8];
   assign cur_y_s     = y_bus[y_base_s +: 10];
   // Modular difference makes sprites near the bottom wrap onto the top lines.
   assign diff_s      = line_y_r - cur_y_s;
   assign hit_s       = cur_attr_s[7] && (diff_s < 10'(SPRITE_H));
   assign row_s       = cur_attr_s[5] ? (4'(SPRITE_H - 1) - diff_s[3:0]) : diff_s[3:0];
   assign store_s     = (state_r == SCAN) && hit_s && (hit_count_r < 4'(MAX_PER_LINE));
   assign scan_done_s = (scan_idx_r == 3'd7);
   assign any_hit_s   = (hit_count_r != 4'd0) || store_s;
   assign xfer_s      = (state_r == EMIT) && out_valid_r && out_ready;
   assign last_s      = xfer_s && ((emit_ptr_r + 4'd1) == hit_count_r);

   // State register; reset wins over everything else.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a line_start in any state (re)starts the scan.
   always_comb begin
      state_next_s = state_r;
      if (line_start) begin
         state_next_s = SCAN;
      end else begin
         case (state_r)
            IDLE: state_next_s = IDLE;
            SCAN: begin
               if (scan_done_s) begin
                  state_next_s = any_hit_s ? EMIT : IDLE;
               end else begin
                  state_next_s = SCAN;
               end
            end
            EMIT: begin
               if (last_s) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = EMIT;
               end
            end
            default: state_next_s = IDLE;
         endcase
      end
   end

   // Datapath next values: scan bookkeeping, entry buffer and the output register.
   always_comb begin
      line_y_n    = line_y_r;
      scan_idx_n  = scan_idx_r;
      emit_ptr_n  = emit_ptr_r;
      hit_count_n = hit_count_r;
      overflow_n  = overflow_r;
      out_valid_n = out_valid_r;
      out_index_n = out_index_r;
      out_attr_n  = out_attr_r;
      out_row_n   = out_row_r;
      buf_index_n = buf_index_r;
      buf_attr_n  = buf_attr_r;
      buf_row_n   = buf_row_r;
      if (line_start) begin
         line_y_n    = line_y;
         scan_idx_n  = 3'd0;
         emit_ptr_n  = 4'd0;
         hit_count_n = 4'd0;
         overflow_n  = 1'b0;
         out_valid_n = 1'b0;
         out_index_n = 3'd0;
         out_attr_n  = 8'd0;
         out_row_n   = 4'd0;
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            buf_index_n[i] = 3'd0;
            buf_attr_n[i]  = 8'd0;
            buf_row_n[i]   = 4'd0;
         end
      end else begin
         case (state_r)
            SCAN: begin
               scan_idx_n = scan_idx_r + 3'd1;
               if (store_s) begin
                  for (int i = 0; i < MAX_PER_LINE; i++) begin
                     if (hit_count_r == 4'(i)) begin
                        buf_index_n[i] = scan_idx_r;
                        buf_attr_n[i]  = cur_attr_s;
                        buf_row_n[i]   = row_s;
                     end else begin
                        buf_index_n[i] = buf_index_r[i];
                     end
                  end
                  hit_count_n = hit_count_r + 4'd1;
               end else if (hit_s) begin
                  overflow_n = 1'b1;
               end else begin
                  overflow_n = overflow_r;
               end
               // First entry goes straight to the output register as EMIT begins.
               if (scan_done_s && any_hit_s) begin
                  out_valid_n = 1'b1;
                  emit_ptr_n  = 4'd0;
                  out_index_n = buf_index_n[0];
                  out_attr_n  = buf_attr_n[0];
                  out_row_n   = buf_row_n[0];
               end else begin
                  out_valid_n = out_valid_r;
               end
            end
            EMIT: begin
               if (last_s) begin
                  out_valid_n = 1'b0;
               end else if (xfer_s) begin
                  emit_ptr_n = emit_ptr_r + 4'd1;
                  for (int i = 0; i < MAX_PER_LINE; i++) begin
                     if ((emit_ptr_r + 4'd1) == 4'(i)) begin
                        out_index_n = buf_index_r[i];
                        out_attr_n  = buf_attr_r[i];
                        out_row_n   = buf_row_r[i];
                     end else begin
                        out_valid_n = 1'b1;
                     end
                  end
               end else begin
                  out_valid_n = out_valid_r;
               end
            end
            default: begin
               scan_idx_n = scan_idx_r;
            end
         endcase
      end
   end

   // Datapath registers; reset discards any pending entries.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         line_y_r    <= 10'd0;
         scan_idx_r  <= 3'd0;
         emit_ptr_r  <= 4'd0;
         hit_count_r <= 4'd0;
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_index_r <= 3'd0;
         out_attr_r  <= 8'd0;
         out_row_r   <= 4'd0;
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            buf_index_r[i] <= 3'd0;
            buf_attr_r[i]  <= 8'd0;
            buf_row_r[i]   <= 4'd0;
         end
      end else begin
         line_y_r    <= line_y_n;
         scan_idx_r  <= scan_idx_n;
         emit_ptr_r  <= emit_ptr_n;
         hit_count_r <= hit_count_n;
         overflow_r  <= overflow_n;
         out_valid_r <= out_valid_n;
         out_index_r <= out_index_n;
         out_attr_r  <= out_attr_n;
         out_row_r   <= out_row_n;
         buf_index_r <= buf_index_n;
         buf_attr_r  <= buf_attr_n;
         buf_row_r   <= buf_row_n;
      end
   end

   assign out_valid = out_valid_r;
   assign out_index = out_index_r;
   assign out_attr  = out_attr_r;
   assign out_row   = out_row_r;
   assign hit_count = hit_count_r;
   assign overflow  = overflow_r;
   assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with hand-computed expectations.
module tb_sprite_line_scanner;

   logic        Clk;
   logic        Reset;
   logic        line_start;
   logic [9:0]  line_y;
   logic [63:0] attr_bus;
   logic [79:0] y_bus;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_index;
   logic [7:0]  out_attr;
   logic [3:0]  out_row;
   logic        busy;
   logic [3:0]  hit_count;
   logic        overflow;

   int passed;
   int failed;
   int total;

   sprite_line_scanner #(.MAX_PER_LINE(4), .SPRITE_H(16)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .line_start (line_start),
      .line_y     (line_y),
      .attr_bus   (attr_bus),
      .y_bus      (y_bus),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_attr   (out_attr),
      .out_row    (out_row),
      .busy       (busy),
      .hit_count  (hit_count),
      .overflow   (overflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_sprite(input int n, input logic [7:0] a, input logic [9:0] y);
      attr_bus[8*n +: 8]  = a;
      y_bus[10*n +: 10]   = y;
   endtask

   task automatic clear_sprites();
      attr_bus = 64'd0;
      y_bus    = 80'd0;
   endtask

   // Pulse line_start for one cycle; returns in cycle 1 of the scan.
   task automatic start_line(input logic [9:0] y);
      line_y     = y;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   logic       pat_ready [6];
   logic [2:0] pat_idx   [6];
   logic [3:0] pat_row   [6];
   int         xfers;

   initial begin
      passed = 0; failed = 0; total = 0;
      Reset = 1'b1; line_start = 1'b0; line_y = 10'd0; out_ready = 1'b0;
      clear_sprites();
      tick(); tick();
      Reset = 1'b0;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_hits", 32'(hit_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_fields", {17'd0, out_index, out_attr, out_row}, 32'd0);

      // Single sprite, latency to first out_valid
      set_sprite(0, 8'h80, 10'd100);
      out_ready = 1'b1;
      start_line(10'd105);
      check("single_busy_c1", 32'(busy), 32'd1);
      repeat (7) tick();
      check("single_valid_c8", 32'(out_valid), 32'd0);
      tick();
      check("single_valid_c9", 32'(out_valid), 32'd1);
      check("single_index", 32'(out_index), 32'd0);
      check("single_attr", 32'(out_attr), 32'h80);
      check("single_row", 32'(out_row), 32'd5);
      check("single_hits", 32'(hit_count), 32'd1);
      check("single_ovf", 32'(overflow), 32'd0);
      tick();
      check("single_done_valid", 32'(out_valid), 32'd0);
      check("single_done_busy", 32'(busy), 32'd0);
      check("single_hold_hits", 32'(hit_count), 32'd1);

      // Vflip, bottom row of the sprite
      clear_sprites();
      set_sprite(3, 8'hA0, 10'd200);
      start_line(10'd215);
      repeat (8) tick();
      check("vflip_valid", 32'(out_valid), 32'd1);
      check("vflip_index", 32'(out_index), 32'd3);
      check("vflip_attr", 32'(out_attr), 32'hA0);
      check("vflip_row", 32'(out_row), 32'd0);
      tick();
      check("vflip_done", 32'(busy), 32'd0);

      // One line past the bottom: no entries
      start_line(10'd216);
      repeat (7) tick();
      check("below_busy_c8", 32'(busy), 32'd1);
      tick();
      check("below_busy_c9", 32'(busy), 32'd0);
      check("below_valid", 32'(out_valid), 32'd0);
      check("below_hits", 32'(hit_count), 32'd0);

      // One line above the top: no entries
      start_line(10'd199);
      repeat (8) tick();
      check("above_valid", 32'(out_valid), 32'd0);
      check("above_hits", 32'(hit_count), 32'd0);
      check("above_busy", 32'(busy), 32'd0);

      // Overflow: all eight hit, first four emitted
      for (int n = 0; n < 8; n++) set_sprite(n, 8'h80, 10'd50);
      start_line(10'd60);
      repeat (8) tick();
      check("ovf_hits", 32'(hit_count), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("ovf_index%0d", i), 32'(out_index), 32'(i));
         check($sformatf("ovf_row%0d", i), 32'(out_row), 32'd10);
         tick();
      end
      check("ovf_end_valid", 32'(out_valid), 32'd0);
      check("ovf_end_busy", 32'(busy), 32'd0);
      check("ovf_hold_flag", 32'(overflow), 32'd1);

      // Backpressure: entries 1, 4 (vflip), 6; sprite 2 on the line but invisible
      clear_sprites();
      set_sprite(1, 8'h81, 10'd10);
      set_sprite(2, 8'h40, 10'd14);
      set_sprite(4, 8'hA2, 10'd12);
      set_sprite(6, 8'h9F, 10'd5);
      out_ready = 1'b0;
      pat_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      pat_idx   = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd6};
      pat_row   = '{4'd4, 4'd4, 4'd4, 4'd13, 4'd13, 4'd9};
      xfers = 0;
      start_line(10'd14);
      repeat (8) tick();
      check("bp_hits", 32'(hit_count), 32'd3);
      for (int s = 0; s < 6; s++) begin
         out_ready = pat_ready[s];
         check($sformatf("bp_valid%0d", s), 32'(out_valid), 32'd1);
         check($sformatf("bp_index%0d", s), 32'(out_index), 32'(pat_idx[s]));
         check($sformatf("bp_row%0d", s), 32'(out_row), 32'(pat_row[s]));
         if (out_valid && out_ready) xfers++;
         tick();
      end
      out_ready = 1'b0;
      check("bp_xfers", 32'(xfers), 32'd3);
      check("bp_end_valid", 32'(out_valid), 32'd0);
      check("bp_end_busy", 32'(busy), 32'd0);

      // Wrap-around hit, then abort during EMIT
      clear_sprites();
      set_sprite(0, 8'h80, 10'd0);
      set_sprite(5, 8'h80, 10'd1020);
      start_line(10'd2);
      repeat (8) tick();
      check("wrap_hits", 32'(hit_count), 32'd2);
      check("wrap_valid", 32'(out_valid), 32'd1);
      check("wrap_index0", 32'(out_index), 32'd0);
      check("wrap_row0", 32'(out_row), 32'd2);
      out_ready = 1'b1;
      tick();
      check("wrap_index1", 32'(out_index), 32'd5);
      check("wrap_row1", 32'(out_row), 32'd6);
      line_y = 10'd500;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      check("abort_hits", 32'(hit_count), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      for (int c = 2; c <= 8; c++) begin
         tick();
         check($sformatf("abort_quiet_c%0d", c), 32'(out_valid), 32'd0);
      end
      check("abort_busy_c8", 32'(busy), 32'd1);
      tick();
      check("abort_busy_c9", 32'(busy), 32'd0);
      check("abort_end_valid", 32'(out_valid), 32'd0);

      // Reset during SCAN at cycle 4
      clear_sprites();
      set_sprite(0, 8'h80, 10'd100);
      start_line(10'd100);
      repeat (3) tick();
      check("mid_hits", 32'(hit_count), 32'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_hits", 32'(hit_count), 32'd0);
      check("rstmid_ovf", 32'(overflow), 32'd0);

      // Reset beats a simultaneous line_start
      Reset = 1'b1;
      line_start = 1'b1;
      tick();
      Reset = 1'b0;
      line_start = 1'b0;
      check("rstprio_busy", 32'(busy), 32'd0);
      repeat (9) tick();
      check("rstprio_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
